// File: rtl/reaction_game_ctrl.sv
// Reaction-timer round sequencer: random ARM delay, LED stimulus, tick-based
// latency measurement, false-start/timeout detection and best-score tracking.
module reaction_game_ctrl #(
  parameter int TICK_DIV       = 1000,
  parameter int TIME_W         = 8,
  parameter int DELAY_MIN      = 500,
  parameter int DELAY_RND_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              button,
  output logic              led_on,
  output logic [TIME_W-1:0] time_out,
  output logic [TIME_W-1:0] best_out,
  output logic [2:0]        state_out,
  output logic              false_start,
  output logic              timeout,
  output logic              done
);

  localparam int DLY_MAX = DELAY_MIN + (2 ** DELAY_RND_BITS) - 1;
  localparam int DLY_W   = $clog2(DLY_MAX + 1) + 1;
  localparam int PRE_W   = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LIT    = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2, r_sync_d;
  logic [7:0]        r_lfsr;
  logic [PRE_W-1:0]  r_presc;
  logic [DLY_W-1:0]  r_delay;
  logic [TIME_W-1:0] r_react;
  logic              r_led;
  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] r_best;
  logic              r_fs, r_to, r_done;

  logic             w_tick;
  logic             w_btn_rise;
  logic             w_lfsr_fb;
  logic [DLY_W-1:0] w_delay_load;

  assign w_tick       = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_btn_rise   = r_sync2 & ~r_sync_d;
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_delay_load = DLY_W'(DELAY_MIN) + DLY_W'(r_lfsr[DELAY_RND_BITS-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
      r_lfsr   <= 8'hA5;
      r_presc  <= '0;
      r_delay  <= '0;
      r_react  <= '0;
      r_led    <= 1'b0;
      r_time   <= '0;
      r_best   <= '1;
      r_fs     <= 1'b0;
      r_to     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // The synchronizer keeps sampling while the tile is disabled; only the
      // edge-detect flop freezes, so a press held across ena=0 is still seen.
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      if (ena) begin
        r_sync_d <= r_sync2;
        r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
        r_presc  <= w_tick ? '0 : r_presc + PRE_W'(1);
        case (r_state)
          S_IDLE, S_RESULT, S_FAULT: begin
            if (start) begin
              r_state <= S_ARM;
              r_presc <= '0;
              r_delay <= w_delay_load;
              r_fs    <= 1'b0;
              r_to    <= 1'b0;
            end
          end
          S_ARM: begin
            if (w_btn_rise) begin
              r_state <= S_FAULT;
              r_fs    <= 1'b1;
              r_time  <= '0;
              r_done  <= 1'b1;
            end else if (w_tick) begin
              if (r_delay == '0) begin
                r_state <= S_LIT;
                r_led   <= 1'b1;
                r_react <= '0;
                r_presc <= '0;
              end else begin
                r_delay <= r_delay - DLY_W'(1);
              end
            end
          end
          S_LIT: begin
            // A press in the saturating cycle still counts as a valid result.
            if (w_btn_rise) begin
              r_state <= S_RESULT;
              r_led   <= 1'b0;
              r_time  <= r_react;
              r_done  <= 1'b1;
              if (r_react < r_best) r_best <= r_react;
            end else if (w_tick) begin
              if (&r_react) begin
                r_state <= S_RESULT;
                r_led   <= 1'b0;
                r_time  <= '1;
                r_to    <= 1'b1;
                r_done  <= 1'b1;
              end else begin
                r_react <= r_react + TIME_W'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign led_on      = r_led;
  assign time_out    = r_time;
  assign best_out    = r_best;
  assign state_out   = r_state;
  assign false_start = r_fs;
  assign timeout     = r_to;
  assign done        = r_done;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: main instance (TIME_W=8) for rounds, reset,
// false start and ena freeze; a TIME_W=4 instance for the saturation timeout.
module tb_reaction_game_ctrl;

  localparam int TICK_DIV = 4;
  localparam int W        = 21;

  logic clk, rst_n, ena;
  logic start, button;
  logic start_t, button_t;

  logic       led_on, false_start, timeout, done;
  logic [7:0] time_out, best_out;
  logic [2:0] state_out;

  logic       led_t, fs_t, to_t, done_t;
  logic [3:0] time_t, best_t;
  logic [2:0] state_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_t_q[$];

  int         n_checks, n_fail;
  logic [7:0] exp_best;
  logic       led_seen, prev_done, prev_done_t;

  reaction_game_ctrl #(.TICK_DIV(TICK_DIV), .TIME_W(8), .DELAY_MIN(2), .DELAY_RND_BITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .button(button),
    .led_on(led_on), .time_out(time_out), .best_out(best_out), .state_out(state_out),
    .false_start(false_start), .timeout(timeout), .done(done)
  );

  reaction_game_ctrl #(.TICK_DIV(TICK_DIV), .TIME_W(4), .DELAY_MIN(2), .DELAY_RND_BITS(2)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_t), .button(button_t),
    .led_on(led_t), .time_out(time_t), .best_out(best_t), .state_out(state_t),
    .false_start(fs_t), .timeout(to_t), .done(done_t)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [7:0] t,
                                        input logic [7:0] b, input logic fs, input logic to);
    return {st, t, b, fs, to};
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (led_on) led_seen <= 1'b1;
    if (prev_done) check("done_pulse", done, 0);
    prev_done <= done;
    if (done) begin
      check("sb_depth", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("state", state_out, e[20:18]);
        check("time_out", time_out, e[17:10]);
        check("best_out", best_out, e[9:2]);
        check("false_start", false_start, e[1]);
        check("timeout", timeout, e[0]);
        check("led_off", led_on, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (prev_done_t) check("t_done_pulse", done_t, 0);
    prev_done_t <= done_t;
    if (done_t) begin
      check("t_sb_depth", exp_t_q.size() > 0, 1);
      if (exp_t_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_t_q.pop_front();
        check("t_state", state_t, e[20:18]);
        check("t_time_out", {4'h0, time_t}, e[17:10]);
        check("t_best_out", {4'h0, best_t}, e[9:2]);
        check("t_false_start", fs_t, e[1]);
        check("t_timeout", to_t, e[0]);
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_led();
    for (int i = 0; i < 200 && !led_on; i++) @(negedge clk);
    check("led_wait", led_on, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // press so the DUT acts while react_cnt holds n
  task automatic play_round(input int n);
    pulse_start();
    wait_led();
    repeat (TICK_DIV * n) @(negedge clk);
    if (n < exp_best) exp_best = 8'(n);
    exp_q.push_back(pack(3'd3, 8'(n), exp_best, 1'b0, 1'b0));
    button = 1'b1;
    drain("round_drain");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    led_seen = 0; prev_done = 0; prev_done_t = 0;
    rst_n = 0; ena = 1; start = 0; button = 0; start_t = 0; button_t = 0;
    exp_best = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_state", state_out, 0);
    check("rst_led", led_on, 0);
    check("rst_time", time_out, 0);
    check("rst_best", best_out, 8'hFF);
    check("rst_fs", false_start, 0);
    check("rst_to", timeout, 0);
    check("rst_done", done, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    play_round(5);

    // asynchronous reset in the middle of LIT
    pulse_start();
    wait_led();
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("amid_state", state_out, 0);
    check("amid_led", led_on, 0);
    check("amid_best", best_out, 8'hFF);
    check("amid_time", time_out, 0);
    exp_best = 8'hFF;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    play_round(7);
    play_round(3);
    play_round(3);

    // false start
    led_seen = 0;
    pulse_start();
    exp_q.push_back(pack(3'd4, 8'd0, exp_best, 1'b1, 1'b0));
    button = 1'b1;
    drain("fs_drain");
    check("fs_led_never", led_seen, 0);
    pulse_start();
    check("fs_cleared", false_start, 0);
    check("fs_arm", state_out, 1);
    wait_led();
    repeat (TICK_DIV * 4) @(negedge clk);
    if (4 < exp_best) exp_best = 8'd4;
    exp_q.push_back(pack(3'd3, 8'd4, exp_best, 1'b0, 1'b0));
    button = 1'b1;
    drain("fs_next_drain");

    // ena freeze in LIT: 6 ticks counted with ena=1 only
    pulse_start();
    wait_led();
    repeat (8) @(negedge clk);
    ena = 0;
    check("ena_state_a", state_out, 2);
    repeat (50) @(negedge clk);
    check("ena_state_b", state_out, 2);
    check("ena_led", led_on, 1);
    ena = 1;
    repeat (TICK_DIV * 6 - 8) @(negedge clk);
    if (6 < exp_best) exp_best = 8'd6;
    exp_q.push_back(pack(3'd3, 8'd6, exp_best, 1'b0, 1'b0));
    button = 1'b1;
    drain("ena_drain");

    // saturation timeout on the narrow instance
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    exp_t_q.push_back(pack(3'd3, 8'h0F, 8'h0F, 1'b0, 1'b1));
    for (int i = 0; i < 500 && exp_t_q.size() != 0; i++) @(negedge clk);
    check("t_drain", exp_t_q.size(), 0);
    check("t_led_off", led_t, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
